// File: rtl/data_mem_access_ctrl_pkg.sv
// Shared RV32 memory-access definitions: load/store codes, access sizes, FSM states, lane masks.
// Used by the MEM-stage controller, the decoder and the EX/MEM stage.
package rv32_mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_size_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_e;

    localparam logic [NBYTES-1:0] LANE_BYTE = 4'b0001;
    localparam logic [NBYTES-1:0] LANE_HALF = 4'b0011;
    localparam logic [NBYTES-1:0] LANE_WORD = 4'b1111;

    // Undefined funct3 codes fall through to a word access.
    function automatic acc_size_e load_size(input logic [2:0] f3);
        acc_size_e sz;
        sz = SZ_WORD;
        if (f3 == F3_LB || f3 == F3_LBU) sz = SZ_BYTE;
        if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
        return sz;
    endfunction

    function automatic logic load_signed(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH);
    endfunction

    function automatic acc_size_e store_size(input logic [1:0] sz_code);
        acc_size_e sz;
        sz = SZ_WORD;
        if (sz_code == ST_SB) sz = SZ_BYTE;
        if (sz_code == ST_SH) sz = SZ_HALF;
        return sz;
    endfunction

    function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] lo);
        logic ok;
        ok = 1'b1;
        if (sz == SZ_HALF) ok = ~lo[0];
        if (sz == SZ_WORD) ok = (lo == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_access_ctrl_if.sv
// Word-wide backing-memory request/ack bus between the MEM-stage controller and memory.
interface data_mem_access_ctrl_if;
    import rv32_mem_pkg::*;

    logic              mm_req;
    logic              mm_we;
    logic [XLEN-1:0]   mm_addr;
    logic [XLEN-1:0]   mm_wdata;
    logic [NBYTES-1:0] mm_byte_en;
    logic [XLEN-1:0]   mm_rdata;
    logic              mm_ack;

    modport master (
        output mm_req, mm_we, mm_addr, mm_wdata, mm_byte_en,
        input  mm_rdata, mm_ack
    );

    modport slave (
        input  mm_req, mm_we, mm_addr, mm_wdata, mm_byte_en,
        output mm_rdata, mm_ack
    );

endinterface

// File: rtl/data_mem_access_ctrl_align.sv
// Combinational lane logic: store data replication and byte enables, load lane extract and extension.
module load_store_align
    import rv32_mem_pkg::*;
(
    input  acc_size_e         i_st_size,
    input  logic [1:0]        i_st_lo,
    input  logic [XLEN-1:0]   i_st_data,
    output logic [XLEN-1:0]   o_st_wdata,
    output logic [NBYTES-1:0] o_st_be,
    input  acc_size_e         i_ld_size,
    input  logic              i_ld_signed,
    input  logic [1:0]        i_ld_lo,
    input  logic [XLEN-1:0]   i_ld_rdata,
    output logic [XLEN-1:0]   o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_rdata[{i_ld_lo, 3'b000} +: 8];
    assign w_half = i_ld_rdata[{i_ld_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_be    = LANE_WORD;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_be    = LANE_BYTE << i_st_lo;
            end
            SZ_HALF: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_be    = LANE_HALF << i_st_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// MEM-stage load/store controller: decodes the EX/MEM request, runs the req/ack access to backing
// memory with a timeout, and stalls the pipeline through busywait until the access completes.
module data_mem_access_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_read,
    input  logic [2:0]            mem_write,
    input  logic [XLEN-1:0]       address,
    input  logic [XLEN-1:0]       write_data,
    output logic                  busywait,
    output logic [XLEN-1:0]       read_data,
    output logic                  misalign_err,
    output logic                  bus_err,
    data_mem_access_ctrl_if.master mm
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    mem_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_load;
    acc_size_e         r_ld_size;
    logic              r_ld_signed;
    logic [1:0]        r_lo;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_req;
    logic              w_aligned;
    acc_size_e         w_size;
    logic [XLEN-1:0]   w_st_wdata;
    logic [NBYTES-1:0] w_st_be;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_timeout;

    // Store has priority when both enables are set.
    always_comb begin
        w_is_store = mem_write[2];
        w_is_load  = mem_read[3] & ~mem_write[2];
        w_req      = w_is_store | w_is_load;
        w_size     = w_is_store ? store_size(mem_write[1:0]) : load_size(mem_read[2:0]);
        w_aligned  = is_aligned(w_size, address[1:0]);
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST));

    assign busywait = ~rst & (((r_state == S_IDLE) & w_req & w_aligned) | (r_state == S_ACCESS));

    load_store_align u_align (
        .i_st_size   (w_size),
        .i_st_lo     (address[1:0]),
        .i_st_data   (write_data),
        .o_st_wdata  (w_st_wdata),
        .o_st_be     (w_st_be),
        .i_ld_size   (r_ld_size),
        .i_ld_signed (r_ld_signed),
        .i_ld_lo     (r_lo),
        .i_ld_rdata  (mm.mm_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_ld_size     <= SZ_WORD;
            r_ld_signed   <= 1'b0;
            r_lo          <= 2'b00;
            read_data     <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            mm.mm_req     <= 1'b0;
            mm.mm_we      <= 1'b0;
            mm.mm_addr    <= '0;
            mm.mm_wdata   <= '0;
            mm.mm_byte_en <= '0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_aligned) begin
                        misalign_err <= 1'b1;
                    end else if (w_req) begin
                        r_state       <= S_ACCESS;
                        r_cnt         <= '0;
                        r_is_load     <= w_is_load;
                        r_ld_size     <= w_size;
                        r_ld_signed   <= load_signed(mem_read[2:0]);
                        r_lo          <= address[1:0];
                        mm.mm_req     <= 1'b1;
                        mm.mm_we      <= w_is_store;
                        mm.mm_addr    <= {address[XLEN-1:2], 2'b00};
                        mm.mm_wdata   <= w_st_wdata;
                        mm.mm_byte_en <= w_is_store ? w_st_be : LANE_WORD;
                    end
                end
                S_ACCESS: begin
                    if (mm.mm_ack) begin
                        mm.mm_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (r_is_load) read_data <= w_ld_data;
                    end else if (w_timeout) begin
                        mm.mm_req <= 1'b0;
                        bus_err   <= 1'b1;
                        r_state   <= S_DONE;
                        if (r_is_load) read_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
